// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the multi-mode sequence generator.
// Mode encodings, per-mode seed constants (sized for the widest register,
// truncated by the user) and the LFSR tap-mask lookup.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'd0,
        MODE_JOHNSON = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_ROT     = 2'd3
    } mode_e;

    localparam int MIN_WIDTH = 3;
    localparam int MAX_WIDTH = 8;

    // Seeds are written at the maximum width; the generator keeps the low WIDTH bits.
    localparam logic [MAX_WIDTH-1:0] SEED_RING      = 8'h01;
    localparam logic [MAX_WIDTH-1:0] SEED_JOHNSON   = 8'h00;
    localparam logic [MAX_WIDTH-1:0] SEED_LFSR      = 8'h01;
    localparam logic [MAX_WIDTH-1:0] SEED_ROT_RESET = 8'h01;

    // Tap mask (bit i set => Q[i] feeds the XOR) giving a maximal-length sequence.
    function automatic logic [MAX_WIDTH-1:0] lfsr_taps(input int width);
        case (width)
            3:       return 8'b0000_0110;
            4:       return 8'b0000_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0000;
            7:       return 8'b0110_0000;
            8:       return 8'b1011_1000;
            default: return 8'b0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/seq_gen_multi_btn_cond.sv
// btn_cond: conditions the raw mode button into a single-cycle rise pulse.
// 2-flop synchroniser, optional debounce filter (SEQ_GEN_DEBOUNCE_EN),
// then an edge register. After reset the pulse is held off until the
// synchronised button has been seen low, so a button held through reset
// never produces an advance.
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic rise
);

    if (DEBOUNCE_CYCLES < 1) begin : g_db_check
        $error("btn_cond: DEBOUNCE_CYCLES must be at least 1");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic       arm_q, arm_d;
    logic [1:0] fill_q, fill_d;
    logic       level;

`ifdef SEQ_GEN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: filtered level follows only after DEBOUNCE_CYCLES differing samples in a row
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce filter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Next state for synchroniser, edge register and post-reset arming
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = level;
        // fill_q[1] marks that sync2_q now reflects the real button, not reset
        fill_d  = {fill_q[0], 1'b1};
        arm_d   = arm_q | (fill_q[1] & ~sync2_q);
    end

    // Synchroniser, edge and arming registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
            fill_q  <= fill_d;
        end
    end

    assign rise = level & ~prev_q & arm_q;

endmodule

// File: rtl/seq_gen_multi.sv
// seq_gen_multi: WIDTH-bit left-shifting sequence generator with four
// feedback modes (ring, Johnson, LFSR, rotate), button-driven mode advance
// with reseed, parallel load and a registered wrap pulse.
// Optional button debounce is compiled in with SEQ_GEN_DEBOUNCE_EN.
module seq_gen_multi
    import seq_gen_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             step_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [1:0]       C,
    output logic [WIDTH-1:0] Q,
    output logic             serial_out,
    output logic             wrap
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("seq_gen_multi: WIDTH must be in 3..8");
    end

    localparam logic [WIDTH-1:0] TAPS        = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_RING_W = WIDTH'(SEED_RING);
    localparam logic [WIDTH-1:0] SEED_JOHN_W = WIDTH'(SEED_JOHNSON);
    localparam logic [WIDTH-1:0] SEED_LFSR_W = WIDTH'(SEED_LFSR);
    localparam logic [WIDTH-1:0] SEED_ROT_W  = WIDTH'(SEED_ROT_RESET);

    mode_e            c_q, c_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rot_seed_q, rot_seed_d;
    logic             wrap_q, wrap_d;
    logic             adv;
    logic             fb;

    btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_cond (
        .clk   (clk),
        .rst   (rst),
        .btn_in(button),
        .rise  (adv)
    );

    // Seed of a mode; rotate takes its seed from the user-loaded register
    function automatic logic [WIDTH-1:0] seed_of(input mode_e m, input logic [WIDTH-1:0] rot);
        case (m)
            MODE_RING:    return SEED_RING_W;
            MODE_JOHNSON: return SEED_JOHN_W;
            MODE_LFSR:    return SEED_LFSR_W;
            default:      return rot;
        endcase
    endfunction

    // Feedback bit shifted into Q[0] for the current mode
    always_comb begin
        fb = 1'b0;
        case (c_q)
            MODE_RING:    fb = (q_q[WIDTH-2:0] == '0);
            MODE_JOHNSON: fb = ~q_q[WIDTH-1];
            MODE_LFSR:    fb = (q_q == '0) ? 1'b1 : ^(q_q & TAPS);
            default:      fb = q_q[WIDTH-1];
        endcase
    end

    // Action priority: mode advance, then load, then step; losers are dropped
    always_comb begin
        c_d        = c_q;
        q_d        = q_q;
        rot_seed_d = rot_seed_q;
        wrap_d     = 1'b0;
        if (adv) begin
            c_d = mode_e'(c_q + 2'd1);
            q_d = seed_of(c_d, rot_seed_q);
        end else if (load) begin
            q_d        = load_data;
            rot_seed_d = load_data;
        end else if (step_en) begin
            q_d    = {q_q[WIDTH-2:0], fb};
            wrap_d = (q_d == seed_of(c_q, rot_seed_q));
        end
    end

    // Mode, register, rotate seed and wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q        <= MODE_RING;
            q_q        <= SEED_RING_W;
            rot_seed_q <= SEED_ROT_W;
            wrap_q     <= 1'b0;
        end else begin
            c_q        <= c_d;
            q_q        <= q_d;
            rot_seed_q <= rot_seed_d;
            wrap_q     <= wrap_d;
        end
    end

    assign C          = c_q;
    assign Q          = q_q;
    assign serial_out = q_q[WIDTH-1];
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_seq_gen_multi.sv
// tb_seq_gen_multi: directed self-checking bench for seq_gen_multi.
// Drives a WIDTH=4 and a WIDTH=8 instance from shared stimulus; the 4-bit
// instance is checked against hand-written sequences, the 8-bit one is used
// for the 255-step LFSR period. Debounce checks apply when
// SEQ_GEN_DEBOUNCE_EN is defined.
module tb_seq_gen_multi;

    localparam int DB = 16;
`ifdef SEQ_GEN_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       step_en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld4 = 4'h0;
    logic [7:0] ld8 = 8'h00;

    logic [1:0] c4, c8;
    logic [3:0] q4;
    logic [7:0] q8;
    logic       so4, so8, wr4, wr8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_gen_multi #(.WIDTH(4), .DEBOUNCE_CYCLES(DB)) dut4 (
        .clk(clk), .rst(rst), .button(button), .step_en(step_en),
        .load(load), .load_data(ld4),
        .C(c4), .Q(q4), .serial_out(so4), .wrap(wr4)
    );

    seq_gen_multi #(.WIDTH(8), .DEBOUNCE_CYCLES(DB)) dut8 (
        .clk(clk), .rst(rst), .button(button), .step_en(step_en),
        .load(load), .load_data(ld8),
        .C(c8), .Q(q8), .serial_out(so8), .wrap(wr8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One step on the 4-bit instance, checking Q, wrap and serial_out
    task automatic step_chk(input string tag, input logic [3:0] eq, input logic ew);
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        check($sformatf("%s Q", tag), q4, eq);
        check($sformatf("%s wrap", tag), wr4, ew);
        check($sformatf("%s serial", tag), so4, eq[3]);
    endtask

    // Button press: C must still be old one edge before the advance edge
    task automatic press(input logic [1:0] c_old, input logic [1:0] c_new, input logic [3:0] q_new);
        button = 1'b1;
        repeat (LAT - 1) tick();
        check("press C before", c4, c_old);
        tick();
        check("press C after", c4, c_new);
        check("press Q seed", q4, q_new);
        button = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    logic [3:0] john_seq [8]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] lfsr_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                  4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] ring_seq [8]  = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

    initial begin
        int wraps8;
        int first_wrap8;
        int zero8;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset C", c4, 2'd0);
        check("reset Q", q4, 4'h1);
        check("reset wrap", wr4, 1'b0);
        check("reset serial", so4, 1'b0);
        check("reset Q8", q8, 8'h01);
        rst = 1'b0;
        repeat (4) tick();

        // Ring from seed: wrap after 4th and 8th step
        for (int i = 0; i < 8; i++)
            step_chk($sformatf("ring%0d", i), ring_seq[i], (i == 3) || (i == 7));

        // Load of the ring seed itself does not pulse wrap
        ld4 = 4'h1; ld8 = 8'h01; load = 1'b1;
        tick();
        load = 1'b0;
        check("load seed Q", q4, 4'h1);
        check("load seed wrap", wr4, 1'b0);

        // Ring self-correction from 0110 (also becomes rotate seed)
        ld4 = 4'h6; ld8 = 8'h06; load = 1'b1;
        tick();
        load = 1'b0;
        check("ring load Q", q4, 4'h6);
        step_chk("ring fix0", 4'hC, 1'b0);
        step_chk("ring fix1", 4'h8, 1'b0);
        step_chk("ring fix2", 4'h1, 1'b1);

        // Johnson
        press(2'd0, 2'd1, 4'h0);
        for (int i = 0; i < 8; i++)
            step_chk($sformatf("john%0d", i), john_seq[i], i == 7);

        // LFSR: 4-bit sequence checked, 8-bit period counted
        press(2'd1, 2'd2, 4'h1);
        check("lfsr8 seed", q8, 8'h01);
        wraps8 = 0;
        first_wrap8 = -1;
        zero8 = 0;
        for (int i = 0; i < 255; i++) begin
            if (i < 15) begin
                step_chk($sformatf("lfsr%0d", i), lfsr_seq[i], i == 14);
            end else begin
                step_en = 1'b1;
                tick();
                step_en = 1'b0;
            end
            if (q8 == 8'h00) zero8++;
            if (wr8) begin
                wraps8++;
                if (first_wrap8 < 0) first_wrap8 = i;
            end
        end
        check("lfsr8 final Q", q8, 8'h01);
        check("lfsr8 wraps", wraps8, 1);
        check("lfsr8 wrap step", first_wrap8, 254);
        check("lfsr8 zeros", zero8, 0);

        // Rotate: seed is the 0110 loaded in ring mode
        press(2'd2, 2'd3, 4'h6);
        ld4 = 4'hA; ld8 = 8'h0A; load = 1'b1; step_en = 1'b1;
        tick();
        load = 1'b0; step_en = 1'b0;
        check("rot load Q", q4, 4'hA);
        check("rot load wrap", wr4, 1'b0);
        step_chk("rot0", 4'h5, 1'b0);
        step_chk("rot1", 4'hA, 1'b1);
        step_chk("rot2", 4'h5, 1'b0);
        step_chk("rot3", 4'hA, 1'b1);

        // Button, load and step together: advance wins, load dropped
        button = 1'b1;
        repeat (LAT - 1) tick();
        ld4 = 4'h7; ld8 = 8'h07; load = 1'b1; step_en = 1'b1;
        tick();
        load = 1'b0; step_en = 1'b0;
        check("prio C", c4, 2'd0);
        check("prio Q", q4, 4'h1);
        check("prio wrap", wr4, 1'b0);
        button = 1'b0;
        repeat (LAT + 2) tick();

        // Cycle back to rotate: seed must still be 1010
        press(2'd0, 2'd1, 4'h0);
        press(2'd1, 2'd2, 4'h1);
        press(2'd2, 2'd3, 4'hA);

        // Async reset mid-press, button held across release
        button = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        check("async rst C", c4, 2'd0);
        check("async rst Q", q4, 4'h1);
        check("async rst serial", so4, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        repeat (LAT + 6) tick();
        check("held through rst C", c4, 2'd0);
        button = 1'b0;
        repeat (LAT + 2) tick();
        press(2'd0, 2'd1, 4'h0);

`ifdef SEQ_GEN_DEBOUNCE_EN
        // Short glitch is filtered out
        button = 1'b1;
        repeat (10) tick();
        button = 1'b0;
        repeat (40) tick();
        check("glitch C", c4, 2'd1);
        // Full press advances at k+18
        press(2'd1, 2'd2, 4'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_gen_multi.md
# seq_gen_multi

Parametrised multi-mode shift-register sequence generator for the lab board. A WIDTH-bit left-shifting register with four feedback modes: self-correcting ring, Johnson, maximal-length LFSR and user-loaded rotate. A push-button cycles the mode and the register is reseeded on every mode change. Sits between the board button/clock-enable logic and the LED/seven-segment display path, and is the generalised successor of the fixed 4-bit, 4-mode generator.

## Interface
- WIDTH, 4, register width; legal range 3..8 (elaboration error otherwise)
- DEBOUNCE_CYCLES, 16, stable-cycle count for the button filter (used only with debounce compiled in)

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- button  input  1  raw mode-advance push-button, asynchronous to clk
- step_en  input  1  advance the register one step this cycle
- load  input  1  load load_data into Q this cycle
- load_data  input  WIDTH  parallel load value; also the mode-3 seed
- C  output  2  current mode: 0 ring, 1 Johnson, 2 LFSR, 3 rotate
- Q  output  WIDTH  register contents
- serial_out  output  1  equals Q[WIDTH-1]
- wrap  output  1  one-cycle pulse when a step returns Q to the current seed

## Operation
- Step: Q <= {Q[WIDTH-2:0], D}. D depends on C:
  - 0 ring: D = (Q[WIDTH-2:0] == 0). Self-correcting; period WIDTH.
  - 1 Johnson: D = ~Q[WIDTH-1]. Period 2·WIDTH from the all-zero seed.
  - 2 LFSR: D = XOR of the tap bits for WIDTH. Taps: 3:{2,1}, 4:{3,2}, 5:{4,2}, 6:{5,4}, 7:{6,5}, 8:{7,5,4,3}. If Q == 0, D = 1 (lockup escape). Period 2^WIDTH−1.
  - 3 rotate: D = Q[WIDTH-1]. Period divides WIDTH.
- Seeds:
  - ring 0…01, Johnson 0…0, LFSR 0…01.
  - Rotate uses a seed register, reset to 0…01. It is updated with load_data on every accepted load, in any mode.
- Mode advance:
  - A rising edge of the conditioned button sets C <= C+1, wrapping 3→0.
  - In the same cycle, Q is loaded with the seed of the new mode.
- Priority per cycle: mode advance > load > step. Lower-priority actions in the same cycle are dropped, not deferred.
- load: Q <= load_data. It does not change C. In modes 0–2 the seed is unchanged.
- wrap:
  - Asserted on the cycle after a step whose new Q equals the current mode's seed.
  - Never asserted on load or mode-advance cycles.
- Reset (async, immediate): C=0, Q=0…01, rotate seed=0…01, wrap=0, serial_out=0, synchroniser/filter/edge state cleared (button treated as low).
- Reset mid-sequence discards all state. No pending button edge survives reset.

## Timing
- Button path: 2-flop synchroniser, then edge register.
  - Button high at clk edge k → C and Q reseeded at edge k+2, visible after it.
  - A button held high gives exactly one advance.
- Step/load: single-cycle; Q updates at the edge where step_en/load is sampled high.
- wrap is registered: high for exactly the cycle after the wrapping step.
- serial_out is combinational from Q: zero added latency.
- No throughput limit: step_en may be high every cycle.

## Configuration
- SEQ_GEN_DEBOUNCE_EN defined:
  - The synchronised button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the filtered level changes.
  - Mode-advance latency becomes k+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES cause no advance.
- Undefined: no filter. Every synchronised rising edge advances the mode.

## Structure
- seq_gen_pkg:
  - Mode encodings (MODE_RING, MODE_JOHNSON, MODE_LFSR, MODE_ROT).
  - Function returning the LFSR tap mask for a given WIDTH.
  - Seed constants per mode.
- Sub-module btn_cond: synchroniser, optional debounce, rising-edge pulse. Parameterised by DEBOUNCE_CYCLES; outputs a one-cycle rise pulse.
- Feedback select, seed mux, priority logic and wrap register are in seq_gen_multi.

## Test plan
- Reset, WIDTH=4, mode 0, step_en held 8 cycles → Q = 0001,0010,0100,1000,0001,…; wrap pulses after the 4th and 8th steps.
- Mode 0, load 0110 then step → Q sequence self-corrects to one-hot 0001 within 4 steps.
- One button press (no debounce) → C=1, Q=0000 at edge k+2. 8 steps → Q=0001,0011,0111,1111,1110,1100,1000,0000; wrap after the 8th step.
- Mode 2, WIDTH=4, 15 steps from 0001 → Q = 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001. wrap once, 0000 never seen. Repeat for WIDTH=8: period 255.
- Mode 3, load 1010 together with step → Q=1010, no shift. Then 4 steps → 0101,1010,0101,1010; wrap after steps 2 and 4. Button and load in the same cycle → mode advances to 0, Q=0001, rotate seed still updated only if load was accepted (it is not).
- SEQ_GEN_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - 10-cycle button glitch → C unchanged.
  - 20-cycle press → C increments at k+18.
  - Assert rst mid-press → C=0 immediately, and no advance after reset release while the button is still high.
